// File: rtl/aes_trace_sequencer.sv
// Batch sequencer that drives an AES core for side-channel traces: load, wait busy, run, gap, repeat.
// Registered results/status; core_load_o and trigger_o decode state directly; abort_i or a timeout ends the batch.
module aes_trace_sequencer #(
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [15:0]  count_i,
  input  logic         mode_i,
  input  logic         dec_i,
  input  logic [127:0] pt_i,
  output logic         core_load_o,
  output logic [127:0] core_data_o,
  output logic         core_dec_o,
  input  logic         core_busy_i,
  input  logic [127:0] core_data_i,
  output logic         trigger_o,
  output logic         busy_o,
  output logic         result_valid_o,
  output logic         done_o,
  output logic         err_o,
  output logic [127:0] result_o,
  output logic [15:0]  ops_done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  // Last counter value before a timeout or gap expiry; zero-length settings collapse to one cycle.
  localparam logic [31:0] TMO_LAST = (TIMEOUT > 0)    ? 32'(TIMEOUT - 1)    : 32'd0;
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

  state_t         state_q, state_d;
  logic [31:0]    cnt_q;
  logic [15:0]    remaining_q;
  logic [15:0]    ops_done_q;
  logic           mode_q;
  logic           dec_q;
  logic [127:0]   data_q;
  logic [127:0]   result_q;
  logic           rvalid_q;
  logic           err_q;
  logic           done_q;

  logic           accept;
  logic           capture;
  logic           set_err;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    set_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = (count_i != 16'd0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (core_busy_i) begin
          state_d = S_RUN;
        end else if (cnt_q == TMO_LAST) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        if (!core_busy_i) begin
          capture = 1'b1;
          state_d = (remaining_q == 16'd1) ? S_DONE : S_GAP;
        end else if (cnt_q == TMO_LAST) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_LOAD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every in-flight event; IDLE and DONE have nothing to abort.
    if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
      state_d = S_DONE;
      capture = 1'b0;
      set_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      remaining_q <= '0;
      ops_done_q  <= '0;
      mode_q      <= 1'b0;
      dec_q       <= 1'b0;
      data_q      <= '0;
      result_q    <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_q == S_DONE);
      rvalid_q <= capture;
      cnt_q    <= (state_d != state_q) ? '0 : cnt_q + 32'd1;

      if (accept) begin
        err_q <= 1'b0;
        if (count_i != 16'd0) begin
          remaining_q <= count_i;
          ops_done_q  <= '0;
          mode_q      <= mode_i;
          dec_q       <= dec_i;
          data_q      <= pt_i;
        end
      end

      if (capture) begin
        result_q    <= core_data_i;
        remaining_q <= remaining_q - 16'd1;
        if (ops_done_q != 16'hFFFF) ops_done_q <= ops_done_q + 16'd1;
        // Chained mode feeds each result back as the next block.
        if (mode_q) data_q <= core_data_i;
      end

      if (set_err) err_q <= 1'b1;
    end
  end

  assign core_load_o    = (state_q == S_LOAD) && !abort_i;
  assign core_data_o    = data_q;
  assign core_dec_o     = dec_q;
  assign trigger_o      = (state_q == S_LOAD) || (state_q == S_WAIT_BUSY) ||
                          ((state_q == S_RUN) && core_busy_i);
  assign busy_o         = (state_q != S_IDLE);
  assign result_valid_o = rvalid_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign result_o       = result_q;
  assign ops_done_o     = ops_done_q;

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Directed bench for aes_trace_sequencer with a small behavioural core (result = block ^ KEY).
module tb_aes_trace_sequencer;

  localparam logic [127:0] KEY = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] P2  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam int           OP  = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i, abort_i, mode_i, dec_i;
  logic [15:0]  count_i;
  logic [127:0] pt_i;
  logic         core_load_o, core_dec_o, core_busy_i;
  logic [127:0] core_data_o, core_data_i;
  logic         trigger_o, busy_o, result_valid_o, done_o, err_o;
  logic [127:0] result_o;
  logic [15:0]  ops_done_o;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int n_load = 0, n_rv = 0, n_done = 0;
  int ld_cyc [0:63];
  logic [127:0] ld_dat [0:63];
  logic core_en = 1'b1;
  int b_load, b_rv, b_done;

  aes_trace_sequencer #(.GAP_CYCLES(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .count_i(count_i), .mode_i(mode_i), .dec_i(dec_i), .pt_i(pt_i),
    .core_load_o(core_load_o), .core_data_o(core_data_o), .core_dec_o(core_dec_o),
    .core_busy_i(core_busy_i), .core_data_i(core_data_i),
    .trigger_o(trigger_o), .busy_o(busy_o), .result_valid_o(result_valid_o),
    .done_o(done_o), .err_o(err_o), .result_o(result_o), .ops_done_o(ops_done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core: busy from the load cycle for OP negedges, then result = block ^ KEY.
  initial begin
    logic [127:0] blk;
    core_busy_i = 1'b0;
    core_data_i = '0;
    forever begin
      @(negedge clk);
      if (core_load_o && core_en) begin
        blk = core_data_o;
        core_busy_i = 1'b1;
        repeat (OP) @(negedge clk);
        core_busy_i = 1'b0;
        core_data_i = blk ^ KEY;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (core_load_o) begin
        if (n_load < 64) begin
          ld_cyc[n_load] = cyc;
          ld_dat[n_load] = core_data_o;
        end
        n_load++;
      end
      if (result_valid_o) n_rv++;
      if (done_o) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_load = n_load;
    b_rv   = n_rv;
    b_done = n_done;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},   128'(busy_o), 128'd0);
    chk({tag, "_trig"},   128'(trigger_o), 128'd0);
    chk({tag, "_load"},   128'(core_load_o), 128'd0);
    chk({tag, "_done"},   128'(done_o), 128'd0);
    chk({tag, "_err"},    128'(err_o), 128'd0);
    chk({tag, "_rv"},     128'(result_valid_o), 128'd0);
    chk({tag, "_res"},    result_o, 128'd0);
    chk({tag, "_ops"},    128'(ops_done_o), 128'd0);
    chk({tag, "_cdata"},  core_data_o, 128'd0);
  endtask

  task automatic start_batch(input logic [15:0] cnt, input logic md, input logic dc, input logic [127:0] pt);
    start_i = 1'b1; count_i = cnt; mode_i = md; dec_i = dc; pt_i = pt;
    tick();
    start_i = 1'b0; count_i = '0; pt_i = '0; mode_i = 1'b0; dec_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; count_i = '0;
    mode_i = 1'b0; dec_i = 1'b0; pt_i = '0;
    repeat (3) tick();
    chk_idle_zero("reset");
    rst_n = 1'b1;
    tick();

    // Fixed mode, three ops on a zero block.
    snap();
    start_batch(16'd3, 1'b0, 1'b1, 128'h0);
    chk("fix_busy", 128'(busy_o), 128'd1);
    chk("fix_trig_load", 128'(trigger_o), 128'd1);
    for (int i = 0; i < 200 && (n_done - b_done) < 1; i++) tick();
    chk("fix_done_seen", 128'(n_done - b_done), 128'd1);
    chk("fix_loads", 128'(n_load - b_load), 128'd3);
    chk("fix_rvs", 128'(n_rv - b_rv), 128'd3);
    chk("fix_ops", 128'(ops_done_o), 128'd3);
    chk("fix_err", 128'(err_o), 128'd0);
    chk("fix_res", result_o, KEY);
    chk("fix_dec", 128'(core_dec_o), 128'd1);
    chk("fix_sp1", 128'(ld_cyc[b_load + 1] - ld_cyc[b_load]), 128'd8);
    chk("fix_sp2", 128'(ld_cyc[b_load + 2] - ld_cyc[b_load + 1]), 128'd8);
    chk("fix_dat3", ld_dat[b_load + 2], 128'h0);
    repeat (3) tick();
    chk("fix_one_done", 128'(n_done - b_done), 128'd1);
    chk("fix_idle", 128'(busy_o), 128'd0);

    // Chained mode, two ops.
    snap();
    start_batch(16'd2, 1'b1, 1'b0, P2);
    for (int i = 0; i < 200 && (n_done - b_done) < 1; i++) tick();
    chk("chn_done_seen", 128'(n_done - b_done), 128'd1);
    chk("chn_dat1", ld_dat[b_load], P2);
    chk("chn_dat2", ld_dat[b_load + 1], P2 ^ KEY);
    chk("chn_res", result_o, P2);
    chk("chn_ops", 128'(ops_done_o), 128'd2);
    chk("chn_dec", 128'(core_dec_o), 128'd0);
    repeat (3) tick();

    // Core never goes busy: err 8 cycles after WAIT_BUSY entry, done one cycle later.
    core_en = 1'b0;
    snap();
    start_batch(16'd1, 1'b0, 1'b0, 128'h5);
    tick();
    chk("tmo_wait_busy", 128'(busy_o), 128'd1);
    chk("tmo_wait_trig", 128'(trigger_o), 128'd1);
    repeat (7) tick();
    chk("tmo_err_early", 128'(err_o), 128'd0);
    chk("tmo_busy_early", 128'(busy_o), 128'd1);
    tick();
    chk("tmo_err_set", 128'(err_o), 128'd1);
    chk("tmo_trig_off", 128'(trigger_o), 128'd0);
    chk("tmo_done_early", 128'(done_o), 128'd0);
    tick();
    chk("tmo_done", 128'(done_o), 128'd1);
    chk("tmo_idle", 128'(busy_o), 128'd0);
    tick();
    chk("tmo_done_pulse", 128'(done_o), 128'd0);
    chk("tmo_err_hold", 128'(err_o), 128'd1);
    chk("tmo_one_load", 128'(n_load - b_load), 128'd1);
    core_en = 1'b1;
    repeat (2) tick();

    // Abort during RUN of op 2 of 5.
    snap();
    start_batch(16'd5, 1'b0, 1'b0, 128'h77);
    chk("abt_err_clr", 128'(err_o), 128'd0);
    for (int i = 0; i < 200 && (n_load - b_load) < 2; i++) tick();
    tick();
    chk("abt_run_trig", 128'(trigger_o), 128'd1);
    chk("abt_run_busy", 128'(core_busy_i), 128'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abt_trig_fell", 128'(trigger_o), 128'd0);
    chk("abt_ops", 128'(ops_done_o), 128'd1);
    tick();
    chk("abt_done", 128'(done_o), 128'd1);
    chk("abt_err", 128'(err_o), 128'd0);
    chk("abt_rvs", 128'(n_rv - b_rv), 128'd1);
    repeat (8) tick();

    // Zero-length batch: done two cycles after start, no load.
    snap();
    start_i = 1'b1; count_i = 16'd0;
    tick();
    start_i = 1'b0;
    chk("zero_busy", 128'(busy_o), 128'd1);
    chk("zero_done_early", 128'(done_o), 128'd0);
    tick();
    chk("zero_done", 128'(done_o), 128'd1);
    chk("zero_noload", 128'(n_load - b_load), 128'd0);
    chk("zero_err", 128'(err_o), 128'd0);
    repeat (2) tick();

    // Reset during GAP abandons the batch silently.
    snap();
    start_batch(16'd3, 1'b0, 1'b1, 128'h99);
    for (int i = 0; i < 200 && (n_rv - b_rv) < 1; i++) tick();
    chk("rst_first_rv", 128'(n_rv - b_rv), 128'd1);
    rst_n = 1'b0;
    tick();
    chk_idle_zero("rst_gap");
    rst_n = 1'b1;
    repeat (12) tick();
    chk("rst_no_done", 128'(n_done - b_done), 128'd0);
    chk("rst_no_reload", 128'(n_load - b_load), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
